// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - round-robin 4-channel scanner driving a 4-to-1 mux select
//
// Purpose:
//   Arbitrates among four level-sensitive requesters, drives the mux41
//   select, waits SETTLE cycles, then captures the mux output into a
//   valid-qualified result and acknowledges the served channel.
//
// Parameters:
//   W       data width of the mux inputs/output
//   SETTLE  cycles the select is held before capture (1..15)
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   en        scan enable; gates new grants only
//   req[3:0]  per-channel request (bit0=a .. bit3=d)
//   y         mux41 output, selected by s
//   s         mux41 select, registered
//   dout      captured data
//   dout_ch   channel index of dout
//   dout_vld  one-cycle pulse when dout/dout_ch update
//   ack[3:0]  one-hot one-cycle pulse to the served channel
//   busy      high whenever the FSM is not idle

module mux_scan_ctrl #(
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [3:0]   req,
    input  logic [W-1:0] y,
    output logic [1:0]   s,
    output logic [W-1:0] dout,
    output logic [1:0]   dout_ch,
    output logic         dout_vld,
    output logic [3:0]   ack,
    output logic         busy
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        CAP  = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [1:0]     ptr, ptr_n;
    logic [3:0]     cnt, cnt_n;
    logic [1:0]     s_n;
    logic [W-1:0]   dout_n;
    logic [1:0]     dout_ch_n;
    logic           dout_vld_n;
    logic [3:0]     ack_n;

    logic [1:0]     winner;
    logic [1:0]     idx;
    logic           found;

    // Rotating priority search: first set request at ptr, ptr+1, ... (mod 4).
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + i[1:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            cnt      <= 4'd0;
            s        <= 2'd0;
            dout     <= '0;
            dout_ch  <= 2'd0;
            dout_vld <= 1'b0;
            ack      <= 4'd0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            s        <= s_n;
            dout     <= dout_n;
            dout_ch  <= dout_ch_n;
            dout_vld <= dout_vld_n;
            ack      <= ack_n;
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        cnt_n      = cnt;
        s_n        = s;
        dout_n     = dout;
        dout_ch_n  = dout_ch;
        dout_vld_n = 1'b0;
        ack_n      = 4'd0;
        case (state)
            IDLE: begin
                // s is left on its last value while idle
                if (en && (req != 4'd0)) begin
                    s_n     = winner;
                    cnt_n   = CNT_INIT;
                    state_n = SEL;
                end
            end
            SEL: begin
                if (cnt == 4'd0) begin
                    state_n = CAP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            CAP: begin
                dout_n     = y;
                dout_ch_n  = s;
                dout_vld_n = 1'b1;
                ack_n      = 4'b0001 << s;
                ptr_n      = s + 2'd1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed self-checking bench for mux_scan_ctrl

module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    // SETTLE=1 instance
    logic       en;
    logic [3:0] req;
    logic [3:0] a, b, c, d, y;
    logic [1:0] s;
    logic [3:0] dout;
    logic [1:0] dout_ch;
    logic       dout_vld;
    logic [3:0] ack;
    logic       busy;

    // SETTLE=3 instance
    logic       en3;
    logic [3:0] req3;
    logic [3:0] d3, y3;
    logic [1:0] s3;
    logic [3:0] dout3;
    logic [1:0] dout_ch3;
    logic       dout_vld3;
    logic [3:0] ack3;
    logic       busy3;

    int passed = 0;
    int total  = 0;

    logic [3:0] rr_val [4];
    logic [1:0] ch;

    always #5 clk = ~clk;

    always_comb begin
        case (s)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

    always_comb begin
        y3 = (s3 == 2'd3) ? d3 : 4'd0;
    end

    mux_scan_ctrl #(.W(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .y(y),
        .s(s), .dout(dout), .dout_ch(dout_ch), .dout_vld(dout_vld),
        .ack(ack), .busy(busy)
    );

    mux_scan_ctrl #(.W(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .req(req3), .y(y3),
        .s(s3), .dout(dout3), .dout_ch(dout_ch3), .dout_vld(dout_vld3),
        .ack(ack3), .busy(busy3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 4'd0;
        a = 4'd0; b = 4'd0; c = 4'd0; d = 4'd0;
        en3 = 1'b0; req3 = 4'd0; d3 = 4'd0;
        rr_val[0] = 4'hF; rr_val[1] = 4'hE; rr_val[2] = 4'hC; rr_val[3] = 4'h8;

        // reset state
        step(); step();
        chk("rst_s", s, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_ch", dout_ch, 0);
        chk("rst_vld", dout_vld, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // single request on channel 0
        en = 1'b1; req = 4'b0001; a = 4'hF;
        step();
        chk("t1_grant_s", s, 0);
        chk("t1_grant_busy", busy, 1);
        chk("t1_grant_vld", dout_vld, 0);
        req = 4'd0;
        step();
        chk("t1_sel_busy", busy, 1);
        chk("t1_sel_vld", dout_vld, 0);
        step();
        chk("t1_cap_vld", dout_vld, 1);
        chk("t1_cap_dout", dout, 4'hF);
        chk("t1_cap_ch", dout_ch, 0);
        chk("t1_cap_ack", ack, 4'b0001);
        chk("t1_cap_busy", busy, 0);
        step();
        chk("t1_vld_drop", dout_vld, 0);
        chk("t1_ack_drop", ack, 0);

        // reset pulse so the rotation restarts at channel 0
        rst = 1'b1;
        step();
        rst = 1'b0;

        // all four requesting: 0,1,2,3,0
        a = 4'hF; b = 4'hE; c = 4'hC; d = 4'h8; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            ch = 2'(i % 4);
            step();
            chk("rr_grant_s", s, ch);
            chk("rr_grant_vld", dout_vld, 0);
            step();
            chk("rr_sel_busy", busy, 1);
            step();
            chk("rr_cap_vld", dout_vld, 1);
            chk("rr_cap_dout", dout, rr_val[ch]);
            chk("rr_cap_ch", dout_ch, ch);
            chk("rr_cap_ack", ack, 4'b0001 << ch);
            if (i == 4) req = 4'd0;
        end

        // ptr=1: ch1 first, then search wraps past 2,3 to ch0
        a = 4'h0; b = 4'h1; req = 4'b0011;
        step();
        chk("wrap_grant1_s", s, 1);
        step(); step();
        chk("wrap_cap1_dout", dout, 4'h1);
        chk("wrap_cap1_ch", dout_ch, 1);
        chk("wrap_cap1_ack", ack, 4'b0010);
        step();
        chk("wrap_grant0_s", s, 0);
        step(); step();
        chk("wrap_cap0_dout", dout, 4'h0);
        chk("wrap_cap0_ch", dout_ch, 0);
        chk("wrap_cap0_ack", ack, 4'b0001);
        req = 4'd0;

        // reset mid-SEL aborts the transaction
        req = 4'b0100; a = 4'h9;
        step();
        chk("abort_grant_s", s, 2);
        rst = 1'b1;
        #1;
        chk("abort_async_s", s, 0);
        chk("abort_async_busy", busy, 0);
        step();
        chk("abort_vld", dout_vld, 0);
        chk("abort_ack", ack, 0);
        chk("abort_dout_ch", dout_ch, 0);
        rst = 1'b0; req = 4'b1001;
        step();
        chk("abort_ptr0_s", s, 0);
        req = 4'd0;
        step(); step();
        chk("abort_next_ack", ack, 4'b0001);
        chk("abort_next_dout", dout, 4'h9);

        // en dropped during SEL: in-flight completes, no new grants until en returns
        req = 4'b1111;
        step();
        chk("en_grant_s", s, 1);
        en = 1'b0;
        step(); step();
        chk("en_cap_vld", dout_vld, 1);
        chk("en_cap_ack", ack, 4'b0010);
        chk("en_cap_dout", dout, 4'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en_off_busy", busy, 0);
            chk("en_off_s", s, 1);
            chk("en_off_vld", dout_vld, 0);
        end
        en = 1'b1;
        step();
        chk("en_resume_s", s, 2);
        chk("en_resume_busy", busy, 1);
        step(); step();
        chk("en_resume_ack", ack, 4'b0100);
        chk("en_resume_dout", dout, 4'hC);
        req = 4'd0;

        // SETTLE=3 instance: capture only the value present on the CAP edge
        en3 = 1'b1; req3 = 4'b1000; d3 = 4'h5;
        step();
        chk("s3_grant_s", s3, 3);
        chk("s3_grant_busy", busy3, 1);
        req3 = 4'd0; d3 = 4'h3;
        step();
        chk("s3_sel1_s", s3, 3);
        chk("s3_sel1_vld", dout_vld3, 0);
        d3 = 4'hA;
        step();
        chk("s3_sel2_s", s3, 3);
        chk("s3_sel2_vld", dout_vld3, 0);
        step();
        chk("s3_sel3_s", s3, 3);
        chk("s3_sel3_vld", dout_vld3, 0);
        d3 = 4'h6;
        step();
        chk("s3_cap_vld", dout_vld3, 1);
        chk("s3_cap_dout", dout3, 4'h6);
        chk("s3_cap_ch", dout_ch3, 3);
        chk("s3_cap_ack", ack3, 4'b1000);
        step();
        chk("s3_after_vld", dout_vld3, 0);
        chk("s3_after_ack", ack3, 0);
        chk("s3_hold_dout", dout3, 4'h6);
        chk("s3_after_busy", busy3, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Round-robin scanner that sits directly upstream of the 4-to-1 mux (mux41).
- Arbitrates among four requesting sources and drives the mux select `s`.
- Waits a programmable settle time, then captures the mux output `y` into a registered, valid-qualified result, and acknowledges the served channel.
- Turns the combinational mux into a sequenced, handshaked 4-channel read path.

Parameters:
- W, 4, data width of mux inputs/output; must equal mux41 width.
- SETTLE, 1, cycles `s` is held before capture; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; new grants only when high.
- req  input  4  per-channel request, level-sensitive; bit0=a, bit1=b, bit2=c, bit3=d.
- y  input  W  mux41 output, driven from `s`.
- s  output  2  mux41 select, registered.
- dout  output  W  captured data, registered.
- dout_ch  output  2  channel index of `dout`.
- dout_vld  output  1  one-cycle pulse: `dout`/`dout_ch` updated.
- ack  output  4  one-hot, one-cycle pulse to the served channel, coincident with `dout_vld`.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, immediate):
  - s=0, dout=0, dout_ch=0, dout_vld=0, ack=0, busy=0.
  - State=IDLE, rotate pointer ptr=0, settle counter cnt=0.
  - Asserting rst mid-transaction aborts it; no `dout_vld`/`ack` is issued.
- States: IDLE, SEL, CAP.
- IDLE:
  - If en=1 and req!=0 at edge N:
    - Winner = first set bit of `req` scanning ptr, ptr+1, ... mod 4.
    - s<=winner, cnt<=SETTLE-1, go SEL.
  - Otherwise stay in IDLE. `s` holds its last value; it is never returned to 0 except by reset.
- SEL:
  - If cnt==0, go CAP; else cnt<=cnt-1.
  - Occupies exactly SETTLE cycles.
- CAP (single cycle); on the edge leaving CAP:
  - dout<=y, dout_ch<=s, dout_vld<=1, ack<=onehot(s).
  - ptr<=s+1 mod 4, go IDLE.
- Latency:
  - Request sampled at edge N gives `dout_vld` high in the cycle following edge N+SETTLE+1.
  - With SETTLE=1, that is 2 edges after grant.
- Throughput: at most one grant per SETTLE+2 cycles.
- `dout_vld` and `ack` are high for exactly one cycle; both deassert on the next edge.
- `dout` and `dout_ch` hold until the next capture.
- `req` is sampled only in IDLE:
  - Changes to `req` during SEL/CAP are ignored; the transaction in flight completes.
  - A requester that keeps `req` high after `ack` is served again when its turn in the rotation comes.
- en=0 blocks new grants only; an in-flight transaction completes.
- Fairness:
  - The pointer advances past the served channel, so with all four requesting the service order is 0,1,2,3,0,…
  - A single requester is served repeatedly.
- ptr wraps 3→0; winner search wraps mod 4.
- y is assumed stable after SETTLE cycles; the block does no checking of y.

Test Plan:
- Reset, then en=1, req=0001, mux a=1111 -> s=00; `dout_vld` pulses 2 cycles after grant with dout=1111, dout_ch=0, ack=0001, busy high for 2 cycles.
- req=1111 held, a/b/c/d=1111/1110/1100/1000, SETTLE=1 -> dout sequence 1111,1110,1100,1000,1111; one `dout_vld` every 3 cycles; s=0,1,2,3,0.
- After serving ch1 (ptr=2), req=0011 -> ch0 served next (wrap); b=0001, a=0000 give dout=0000 after dout=0001.
- SETTLE=3, req=1000, d=0101 -> `dout_vld` 4 edges after grant; s=11 held throughout; y changes before capture are ignored; the captured value equals y on the CAP edge.
- rst asserted mid-SEL with req=0100 -> outputs 0 immediately; no `ack`/`dout_vld`; after release, the first grant uses ptr=0.
- en dropped during SEL -> transaction completes (ack pulses); no new grant while en=0 even with req=1111; grants resume on the cycle after en returns high.
